cpu_mem_arbiter: RTL

Arbiter and protocol converter between the CPU's two SRAM-like request ports (instruction fetch and data load/store) and a single unified memory port. It accepts one request at a time from either side, issues it on the memory bus, and returns the response to the side that issued it. It sits directly downstream of the CPU top and carries all of the CPU's memory traffic. Exactly one transaction is outstanding at any time.

---
 rtl/cpu_mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//   Arbitrates the CPU instruction-fetch and data load/store SRAM-like
//   request ports onto one unified memory port. Exactly one transaction is
//   in flight at a time. The response is routed back to the side that
//   issued the request.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   inst_sram_*            instruction read port: req/addr in; addr_ok/data_ok/rdata out
//   data_sram_*            data port: req/wr/wstrb/addr/wdata in; addr_ok/data_ok/rdata out
//   mem_req/wr/addr/wstrb/wdata  unified memory request, held until mem_gnt
//   mem_gnt                memory accepts the request (mem_req & mem_gnt)
//   mem_resp, mem_rdata    one-cycle memory response and read data
//
// Parameter
//   DATA_FIRST             1: data port wins a simultaneous request, 0: instruction port wins
module cpu_mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_dok_q, inst_dok_d;
  logic        data_dok_q, data_dok_d;

  logic inst_acc, data_acc, resp_hit;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_dok_d   = 1'b0;
    data_dok_d   = 1'b0;
    inst_acc     = 1'b0;
    data_acc     = 1'b0;
    resp_hit     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data wins if it has priority or if the instruction side is quiet.
        if (!reset) begin
          if (data_sram_req && (DATA_FIRST || !inst_sram_req)) begin
            data_acc = 1'b1;
          end else if (inst_sram_req) begin
            inst_acc = 1'b1;
          end
        end
        if (data_acc) begin
          owner_d = OWN_DATA;
          addr_d  = data_sram_addr;
          wr_d    = data_sram_wr;
          wstrb_d = data_sram_wstrb;
          wdata_d = data_sram_wdata;
          state_d = REQ;
        end else if (inst_acc) begin
          // Fetches are reads; wdata keeps whatever the last write left.
          owner_d = OWN_INST;
          addr_d  = inst_sram_addr;
          wr_d    = 1'b0;
          wstrb_d = 4'b0000;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp) begin
          resp_hit = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Response routing: pulse goes to the owner, read data only on reads.
    if (resp_hit) begin
      if (owner_q == OWN_DATA) begin
        data_dok_d = 1'b1;
        if (!wr_q) data_rdata_d = mem_rdata;
      end else begin
        inst_dok_d = 1'b1;
        if (!wr_q) inst_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_dok_q   <= 1'b0;
      data_dok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_dok_q   <= inst_dok_d;
      data_dok_q   <= data_dok_d;
    end
  end

  assign inst_sram_addr_ok = inst_acc;
  assign data_sram_addr_ok = data_acc;
  assign inst_sram_data_ok = inst_dok_q;
  assign data_sram_data_ok = data_dok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_rdata   = data_rdata_q;

  assign mem_req   = (state_q == REQ);
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

endmodule
